// File: rtl/updown_counter.sv
// Parameterised up/down counter with load, wrap/saturate limits,
// terminal pulse and sticky overflow.
module updown_counter #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned MAX         = 2**WIDTH-1,
    parameter bit          SATURATE    = 1'b0,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_overflow,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             overflow,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_C   = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_C  = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             term_q, term_d;
    logic             ovf_q, ovf_d;
    logic             limit;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RST_C;
            term_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            term_q  <= term_d;
            ovf_q   <= ovf_d;
        end
    end

    // Limits are tested before any arithmetic so no out-of-range
    // value can be formed when MAX < 2**WIDTH-1.
    always_comb begin
        count_d = count_q;
        limit   = 1'b0;
        if (load) begin
            count_d = (load_value > MAX_C) ? MAX_C : load_value;
        end else if (enable) begin
            if (up) begin
                if (count_q >= MAX_C) begin
                    limit   = 1'b1;
                    count_d = SATURATE ? MAX_C : ZERO_C;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (count_q == ZERO_C) begin
                    limit   = 1'b1;
                    count_d = SATURATE ? ZERO_C : MAX_C;
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end
    end

    // A limit event on the same edge as a clear keeps the flag set.
    always_comb begin
        term_d = limit;
        ovf_d  = limit | (ovf_q & ~clear_overflow);
    end

    assign count    = count_q;
    assign terminal = term_q;
    assign overflow = ovf_q;
    assign zero     = (count_q == ZERO_C);

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: three counter configurations driven in lockstep
// and checked against an arithmetic reference model.
module tb_updown_counter;

    logic       clock = 1'b0;
    logic       reset, enable, up, load, clear_overflow;
    logic [4:0] load_value;

    logic [4:0] c0;
    logic [3:0] c1, c2;
    logic [2:0] t, o, z;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // dut0: defaults (5 bits, MAX 31, wrap, reset 0)
    updown_counter u0 (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .load(load), .load_value(load_value),
        .clear_overflow(clear_overflow),
        .count(c0), .terminal(t[0]), .overflow(o[0]), .zero(z[0])
    );

    // dut1: 4 bits, MAX 9, wrap, reset 3
    updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0),
                     .RESET_VALUE(3)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .load(load), .load_value(load_value[3:0]),
        .clear_overflow(clear_overflow),
        .count(c1), .terminal(t[1]), .overflow(o[1]), .zero(z[1])
    );

    // dut2: 4 bits, MAX 9, saturate, reset 0
    updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1),
                     .RESET_VALUE(0)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .load(load), .load_value(load_value[3:0]),
        .clear_overflow(clear_overflow),
        .count(c2), .terminal(t[2]), .overflow(o[2]), .zero(z[2])
    );

    int W_CFG   [3] = '{5, 4, 4};
    int MAX_CFG [3] = '{31, 9, 9};
    int SAT_CFG [3] = '{0, 0, 1};
    int RV_CFG  [3] = '{0, 3, 0};

    int mc [3];
    int mt [3];
    int mo [3];

    typedef struct {
        int c [3];
        int t [3];
        int o [3];
    } exp_t;

    exp_t sb [$];

    task automatic check(input string name, input int i,
                         input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s dut%0d got %0d want %0d",
                         name, i, got, want);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit u,
                         input bit l, input int lv, input bit clr);
        exp_t x;
        int v;
        bit ev;
        @(negedge clock);
        reset          = r;
        enable         = e;
        up             = u;
        load           = l;
        load_value     = lv[4:0];
        clear_overflow = clr;
        for (int i = 0; i < 3; i++) begin
            ev = 1'b0;
            if (r) begin
                mc[i] = RV_CFG[i];
                mo[i] = 0;
            end else if (l) begin
                v = lv % (1 << W_CFG[i]);
                mc[i] = (v > MAX_CFG[i]) ? MAX_CFG[i] : v;
            end else if (e) begin
                if (u) begin
                    if (mc[i] == MAX_CFG[i]) begin
                        ev = 1'b1;
                        mc[i] = SAT_CFG[i] ? MAX_CFG[i] : 0;
                    end else begin
                        mc[i] = mc[i] + 1;
                    end
                end else begin
                    if (mc[i] == 0) begin
                        ev = 1'b1;
                        mc[i] = SAT_CFG[i] ? 0 : MAX_CFG[i];
                    end else begin
                        mc[i] = mc[i] - 1;
                    end
                end
            end
            if (!r) begin
                if (ev) mo[i] = 1;
                else if (clr) mo[i] = 0;
            end
            mt[i] = ev ? 1 : 0;
            x.c[i] = mc[i];
            x.t[i] = mt[i];
            x.o[i] = mo[i];
        end
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        int ac [3];
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                ac[0] = int'(c0);
                ac[1] = int'(c1);
                ac[2] = int'(c2);
                for (int i = 0; i < 3; i++) begin
                    check("count", i, ac[i], x.c[i]);
                    check("terminal", i, int'(t[i]), x.t[i]);
                    check("overflow", i, int'(o[i]), x.o[i]);
                    check("zero", i, int'(z[i]), (x.c[i] == 0) ? 1 : 0);
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1; enable = 1'b0; up = 1'b0; load = 1'b0;
        load_value = '0; clear_overflow = 1'b0;

        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (33) drive(0, 1, 1, 0, 0, 0);

        drive(0, 0, 0, 1, 2, 1);
        repeat (4) drive(0, 1, 0, 0, 0, 0);

        drive(0, 0, 0, 1, 8, 1);
        repeat (4) drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);

        drive(0, 1, 1, 1, 14, 0);
        drive(1, 0, 0, 1, 14, 0);

        drive(0, 0, 0, 1, 31, 0);
        drive(0, 1, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);

        drive(0, 0, 0, 1, 17, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        repeat (3) drive(0, 1, 1, 0, 0, 0);

        repeat (3000) begin
            drive(($urandom_range(63) == 0),
                  ($urandom_range(3) != 0),
                  $urandom_range(1),
                  ($urandom_range(7) == 0),
                  int'($urandom_range(31)),
                  ($urandom_range(7) == 0));
        end

        for (int k = 0; k < 10 && sb.size() != 0; k++)
            @(posedge clock);
        @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
